arb_rr_pop_sched: RTL and testbench
===================================

// Module: arb_rr_pop_sched
// PURPOSE
// - Round-robin pop scheduler for the 4-FIFO output mux: drives the one-hot arb_pop select lines and the downstream push.
// - Sits between the FIFO_UNITS show-ahead FIFOs (data valid while !empty) and the shared downstream FIFO.
// - Bounded bursts per requester and stall on downstream almost-full.
// PARAMETERS
// - FIFO_UNITS  4   number of requesting FIFOs; one arb_pop bit per FIFO
// - PTR_L       2   width of the binary grant index (clog2 FIFO_UNITS)
// - BURST       4   max consecutive pops granted to one FIFO before rotating (>=1)
// - CNT_W       8   width of per-FIFO grant counters (ARB_GRANT_CNT_EN only)
// PORTS
// - clk              in   1                   single clock, all state on rising edge
// - reset            in   1                   synchronous, active-high
// - arb_en           in   1                   scheduler enable
// - fifo_empty       in   FIFO_UNITS          per-FIFO empty flag
// - down_almost_full in   1                   downstream FIFO almost full, stalls pops
// - arb_pop          out  FIFO_UNITS          one-hot pop to selected FIFO; also mux select
// - arb_push         out  1                   push into downstream FIFO (= |arb_pop)
// - arb_sel          out  PTR_L               registered binary index of current grant (cur)
// - arb_busy         out  1                   state != IDLE
// - grant_cnt        out  FIFO_UNITS*CNT_W    per-FIFO pop counts (only with ARB_GRANT_CNT_EN)
// BEHAVIOUR
// - Reset values: state=IDLE, cur=FIFO_UNITS-1 (first grant goes to FIFO0), burst_cnt=0, arb_pop=0, arb_push=0, arb_sel=FIFO_UNITS-1, arb_busy=0.
// - arb_pop/arb_push are combinational from registered state and live inputs; zero whenever state!=GRANT, reset=1 or arb_en=0.
// - pop = (state==GRANT) && !fifo_empty[cur] && !down_almost_full && arb_en; arb_pop = pop ? onehot(cur) : 0.
// - next(x): first i with !fifo_empty[i], scanning x+1, x+2 ... mod FIFO_UNITS, x itself last. Ties resolved by this rotation only.
// - IDLE:
//   - if arb_en && |~fifo_empty && !down_almost_full: cur<=next(cur), burst_cnt<=0, ->GRANT.
//   - No pop in IDLE, so the first pop occurs 1 cycle after a request is seen.
// - GRANT, pop and burst_cnt==BURST-1: cur<=next(cur), burst_cnt<=0.
//   - If cur is the sole non-empty FIFO it is reselected with no bubble.
// - GRANT, pop otherwise: burst_cnt<=burst_cnt+1, stay.
// - GRANT, fifo_empty[cur]=1 (no pop):
//   - if any FIFO is non-empty: cur<=next(cur), burst_cnt<=0.
//   - else ->IDLE.
//   - Costs one bubble cycle.
// - GRANT, down_almost_full=1: no pop, ->HOLD; cur and burst_cnt kept.
// - HOLD: arb_pop=0; on down_almost_full=0 ->GRANT with the same cur and burst_cnt (burst resumes, not restarted).
// - arb_en=0 in any state: ->IDLE next cycle, burst_cnt<=0, cur kept (fairness preserved across disable).
// - Reset mid-operation: outputs 0 in the reset cycle; after release the first grant is FIFO0.
// - burst_cnt width clog2(BURST+1); never exceeds BURST-1.
// CONFIGURATION
// - ARB_GRANT_CNT_EN defined:
//   - grant_cnt port present; counter i increments on every cycle with arb_pop[i]=1.
//   - Counters saturate at 2^CNT_W-1 and clear to 0 on reset only.
// - ARB_GRANT_CNT_EN undefined: grant_cnt port and counters absent; all other behaviour identical.
// STRUCTURE
// - Package arb_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_GRANT=2'd1, ST_HOLD=2'd2.
//   - default FIFO_UNITS/PTR_L constants.
//   - onehot(idx) function.
// - Sub-module rr_next_pick: combinational next(x) given cur and fifo_empty; outputs index + any_req.
// - Top: FSM, cur/burst_cnt registers, pop gating, optional counters.
// TESTING
// - Reset, fifo_empty=4'b1111 for 20 cycles -> arb_pop=0, arb_push=0, arb_busy=0 throughout.
// - BURST=4, fifo_empty=4'b1110 constant -> 1 IDLE cycle, then arb_pop=4'b0001 every cycle, no bubbles.
// - BURST=2, fifo_empty=4'b0000 -> arb_pop sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001...
// - BURST=2, all non-empty, down_almost_full=1 for 3 cycles after the first FIFO1 pop:
//   - arb_pop=0 and state HOLD for those 3 cycles;
//   - then 0010 once, then 0100.
// - FIFO2 granted, fifo_empty[2] rises mid-burst -> one cycle arb_pop=0, then 1000 (next non-empty).
// - Reset pulsed 1 cycle while granting FIFO2 -> arb_pop=0 in that cycle, IDLE after, next grant 0001.
// - With ARB_GRANT_CNT_EN, CNT_W=4, FIFO0 sole requester for 20 pops -> grant_cnt[3:0]=4'hF (saturated), others 0.

Source files
------------

// File: rtl/arb_rr_pop_sched_pkg.sv
// Shared types and constants for the round-robin pop scheduler.
// State encoding, default sizing and the one-hot select helper.
package arb_pkg;

    localparam int ARB_FIFO_UNITS = 4;
    localparam int ARB_PTR_L      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_e;

    function automatic logic [ARB_FIFO_UNITS-1:0] onehot(input logic [ARB_PTR_L-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/arb_rr_pop_sched_if.sv
// Handshake bundle between the scheduler, the source FIFOs and the downstream FIFO.
// master = scheduler side, slave = FIFO/environment side.
interface arb_rr_pop_sched_if #(
    parameter int FIFO_UNITS = arb_pkg::ARB_FIFO_UNITS,
    parameter int PTR_L      = arb_pkg::ARB_PTR_L
);
    logic                  arb_en;
    logic [FIFO_UNITS-1:0] fifo_empty;
    logic                  down_almost_full;
    logic [FIFO_UNITS-1:0] arb_pop;
    logic                  arb_push;
    logic [PTR_L-1:0]      arb_sel;
    logic                  arb_busy;

    modport master (
        input  arb_en, fifo_empty, down_almost_full,
        output arb_pop, arb_push, arb_sel, arb_busy
    );

    modport slave (
        output arb_en, fifo_empty, down_almost_full,
        input  arb_pop, arb_push, arb_sel, arb_busy
    );
endinterface

// File: rtl/arb_rr_pop_sched_next_pick.sv
// Round-robin successor: first non-empty FIFO after i_cur, wrapping, i_cur itself last.
module rr_next_pick #(
    parameter int FIFO_UNITS = arb_pkg::ARB_FIFO_UNITS,
    parameter int PTR_L      = arb_pkg::ARB_PTR_L
) (
    input  logic [PTR_L-1:0]      i_cur,
    input  logic [FIFO_UNITS-1:0] i_fifo_empty,
    output logic [PTR_L-1:0]      o_idx,
    output logic                  o_any_req
);
    logic             w_found;
    logic [PTR_L-1:0] w_cand;

    always_comb begin
        o_idx   = i_cur;
        w_found = 1'b0;
        w_cand  = i_cur;
        for (int k = 1; k <= FIFO_UNITS; k++) begin
            w_cand = PTR_L'((int'(i_cur) + k) % FIFO_UNITS);
            if (!w_found && !i_fifo_empty[w_cand]) begin
                o_idx   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign o_any_req = ~&i_fifo_empty;
endmodule

// File: rtl/arb_rr_pop_sched.sv
// Round-robin pop scheduler with bounded bursts and downstream almost-full stall.
// Optional per-FIFO saturating pop counters when ARB_GRANT_CNT_EN is defined.
module arb_rr_pop_sched #(
    parameter int FIFO_UNITS = arb_pkg::ARB_FIFO_UNITS,
    parameter int PTR_L      = arb_pkg::ARB_PTR_L,
    parameter int BURST      = 4,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    arb_rr_pop_sched_if.master           arb_bus
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [FIFO_UNITS*CNT_W-1:0]  grant_cnt
`endif
);
    import arb_pkg::*;

    localparam int             BW         = $clog2(BURST + 1);
    localparam logic [BW-1:0]  BURST_LAST = BW'(BURST - 1);

    arb_state_e       r_state, w_state_nxt;
    logic [PTR_L-1:0] r_cur, w_cur_nxt;
    logic [BW-1:0]    r_burst, w_burst_nxt;
    logic [PTR_L-1:0] w_next_idx;
    logic             w_any_req;
    logic             w_pop;

    rr_next_pick #(
        .FIFO_UNITS (FIFO_UNITS),
        .PTR_L      (PTR_L)
    ) u_next_pick (
        .i_cur        (r_cur),
        .i_fifo_empty (arb_bus.fifo_empty),
        .o_idx        (w_next_idx),
        .o_any_req    (w_any_req)
    );

    assign w_pop = !reset && arb_bus.arb_en && (r_state == ST_GRANT)
                   && !arb_bus.fifo_empty[r_cur] && !arb_bus.down_almost_full;

    assign arb_bus.arb_pop  = w_pop ? onehot(r_cur) : '0;
    assign arb_bus.arb_push = w_pop;
    assign arb_bus.arb_sel  = r_cur;
    assign arb_bus.arb_busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cur   <= PTR_L'(FIFO_UNITS - 1);
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    // Almost-full takes priority over an empty current FIFO in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_burst_nxt = r_burst;
        if (!arb_bus.arb_en) begin
            w_state_nxt = ST_IDLE;
            w_burst_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req && !arb_bus.down_almost_full) begin
                        w_cur_nxt   = w_next_idx;
                        w_burst_nxt = '0;
                        w_state_nxt = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (arb_bus.down_almost_full) begin
                        w_state_nxt = ST_HOLD;
                    end else if (arb_bus.fifo_empty[r_cur]) begin
                        if (w_any_req) begin
                            w_cur_nxt   = w_next_idx;
                            w_burst_nxt = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (r_burst == BURST_LAST) begin
                        w_cur_nxt   = w_next_idx;
                        w_burst_nxt = '0;
                    end else begin
                        w_burst_nxt = r_burst + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!arb_bus.down_almost_full) w_state_nxt = ST_GRANT;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] r_grant_cnt [FIFO_UNITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_UNITS; i++) r_grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < FIFO_UNITS; i++) begin
                if (arb_bus.arb_pop[i] && (r_grant_cnt[i] != '1))
                    r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < FIFO_UNITS; g++) begin : g_cnt_out
        assign grant_cnt[g*CNT_W +: CNT_W] = r_grant_cnt[g];
    end
`endif
endmodule

// File: tb/tb_arb_rr_pop_sched.sv
// Self-checking bench for arb_rr_pop_sched: directed scenarios plus random traffic vs a credit-based model.
module tb_arb_rr_pop_sched;
    localparam int N     = 4;
    localparam int BURST = 2;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    arb_rr_pop_sched_if #(.FIFO_UNITS(N), .PTR_L(2)) u_if ();

`ifdef ARB_GRANT_CNT_EN
    logic [N*CNT_W-1:0] grant_cnt;
`endif

    arb_rr_pop_sched #(
        .FIFO_UNITS (N),
        .PTR_L      (2),
        .BURST      (BURST),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .arb_bus (u_if)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: phase 0 = idle, 1 = granting, 2 = stalled; credit = pops left in current burst.
    int m_phase;
    int m_cur;
    int m_credit;
    int m_cnt [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int rr_next(input int cur, input logic [N-1:0] emp);
        for (int k = 1; k <= N; k++) begin
            if (!emp[(cur + k) % N]) return (cur + k) % N;
        end
        return cur;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_cur    = N - 1;
        m_credit = BURST;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic cycle(input logic en, input logic [N-1:0] emp, input logic daf,
                         input logic rst, output logic [N-1:0] pop_o);
        logic [N-1:0] exp_pop;
        u_if.arb_en           = en;
        u_if.fifo_empty       = emp;
        u_if.down_almost_full = daf;
        reset                 = rst;
        @(negedge clk);
        exp_pop = (!rst && en && m_phase == 1 && !emp[m_cur] && !daf) ? N'(1 << m_cur) : '0;
        chk("arb_pop",  32'(u_if.arb_pop),  32'(exp_pop));
        chk("arb_push", 32'(u_if.arb_push), 32'(|exp_pop));
        chk("arb_sel",  32'(u_if.arb_sel),  32'(m_cur));
        chk("arb_busy", 32'(u_if.arb_busy), 32'(m_phase != 0));
`ifdef ARB_GRANT_CNT_EN
        for (int i = 0; i < N; i++)
            chk("grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
`endif
        pop_o = u_if.arb_pop;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++)
                if (exp_pop[i] && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
            if (!en) begin
                m_phase  = 0;
                m_credit = BURST;
            end else if (m_phase == 0) begin
                if (emp != '1 && !daf) begin
                    m_cur    = rr_next(m_cur, emp);
                    m_credit = BURST;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                if (daf) begin
                    m_phase = 2;
                end else if (emp[m_cur]) begin
                    if (emp != '1) begin
                        m_cur    = rr_next(m_cur, emp);
                        m_credit = BURST;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_credit--;
                    if (m_credit == 0) begin
                        m_cur    = rr_next(m_cur, emp);
                        m_credit = BURST;
                    end
                end
            end else if (!daf) begin
                m_phase = 1;
            end
        end
        #1;
    endtask

    task automatic hard_reset();
        logic [N-1:0] p;
        cycle(1'b1, '1, 1'b0, 1'b1, p);
    endtask

    initial begin
        logic [N-1:0] p;
        logic [N-1:0] seq_exp [10];
        n_checks = 0;
        n_fail   = 0;
        seq_exp  = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                     4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

        // DUT registers are unknown before the first reset edge, so this cycle is not checked.
        u_if.arb_en = 1'b1; u_if.fifo_empty = '1; u_if.down_almost_full = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        model_reset();

        hard_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'b1111, 1'b0, 1'b0, p);

        hard_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 4'b1110, 1'b0, 1'b0, p);
            if (i > 0) chk("sole_fifo0", 32'(p), 32'h1);
        end

        hard_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
            chk("rr_seq", 32'(p), 32'(seq_exp[i]));
        end

        // Almost-full stall right after the first FIFO1 pop; the burst then resumes.
        hard_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        chk("first_fifo1", 32'(p), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b0000, 1'b1, 1'b0, p);
            chk("hold_nopop", 32'(p), 32'h0);
        end
        cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        chk("resume_fifo1", 32'(p), 32'h2);
        cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        chk("after_resume", 32'(p), 32'h4);

        // FIFO2 empties mid-burst: one bubble, then FIFO3.
        hard_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        chk("fifo2_granted", 32'(p), 32'h4);
        cycle(1'b1, 4'b0100, 1'b0, 1'b0, p);
        chk("empty_bubble", 32'(p), 32'h0);
        cycle(1'b1, 4'b0100, 1'b0, 1'b0, p);
        chk("skip_to_fifo3", 32'(p), 32'h8);

        // Reset pulse while FIFO2 is granted.
        hard_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        cycle(1'b1, 4'b0000, 1'b0, 1'b1, p);
        chk("pop_in_reset", 32'(p), 32'h0);
        cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        chk("idle_after_rst", 32'(p), 32'h0);
        cycle(1'b1, 4'b0000, 1'b0, 1'b0, p);
        chk("first_after_rst", 32'(p), 32'h1);

`ifdef ARB_GRANT_CNT_EN
        hard_reset();
        for (int i = 0; i < 22; i++) cycle(1'b1, 4'b1110, 1'b0, 1'b0, p);
        chk("cnt_sat", 32'(grant_cnt[CNT_W-1:0]), 32'hF);
        chk("cnt_others", 32'(grant_cnt[N*CNT_W-1:CNT_W]), 32'h0);
`endif

        hard_reset();
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 19) != 0,
                  ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom),
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 99) == 0, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
